keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and ghost rejection.
// Optional entry accumulator enabled by defining KEYPAD_ACCUM_EN.
module keypad_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 230000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] key_value,
  output logic        value_valid
);

  localparam int MAX_DIV = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int CW      = $clog2(MAX_DIV) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [CW-1:0] cnt;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [3:0]    col_mask;
  logic          single_low;
  logic [3:0]    next_row;
  logic [3:0]    pressed_code;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Encodes a one-hot active-high vector; only called on proven one-hot inputs.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign single_low   = $onehot(~col_sync);
  assign next_row     = {row_n[2:0], row_n[3]};
  assign pressed_code = key_map(row_idx, col_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_n     <= 4'b1110;
      cnt       <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      col_mask  <= 4'hF;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (single_low) begin
              row_idx  <= onehot_index(~row_n);
              col_idx  <= onehot_index(~col_sync);
              col_mask <= col_sync;
              state    <= DEBOUNCE;
            end else begin
              row_n <= next_row;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          // Any change, including a second column, abandons this key.
          if (col_sync != col_mask) begin
            state <= SCAN;
            cnt   <= '0;
            row_n <= next_row;
          end else if (cnt == DEB_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          key_code  <= pressed_code;
          key_valid <= 1'b1;
          key_held  <= 1'b1;
          cnt       <= '0;
          state     <= RELEASE;
        end
        RELEASE: begin
          if (col_sync != 4'hF) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            key_held <= 1'b0;
            cnt      <= '0;
            row_n    <= next_row;
            state    <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_ACCUM_EN
  // Updates on the same edge that raises key_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_value   <= 32'h0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (state == PRESSED) begin
        case (pressed_code)
          4'hE:    key_value <= 32'h0;
          4'hF:    value_valid <= 1'b1;
          default: key_value <= {key_value[27:0], pressed_code};
        endcase
      end
    end
  end
`else
  assign key_value   = 32'h0;
  assign value_valid = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan (SCAN_DIV=4, DEB_CYCLES=16).
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] key_value;
  logic        value_valid;

  logic [15:0] press;
  int          total = 0;
  int          bad = 0;
  int          nvalid = 0;
  int          nvv = 0;
  logic [3:0]  last_code = 4'h0;

  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  keypad_scan #(.SCAN_DIV(4), .DEB_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col_n(col_n),
    .row_n(row_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .key_value(key_value),
    .value_valid(value_valid)
  );

  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      nvalid    <= nvalid + 1;
      last_code <= key_code;
    end
    if (value_valid) nvv <= nvv + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hit(input int r, input int c, input string tag);
    int base;
    int t;
    base = nvalid;
    press[r*4+c] = 1'b1;
    t = 0;
    while (nvalid == base && t < 100) begin
      step(1);
      t++;
    end
    step(10);
    press[r*4+c] = 1'b0;
    t = 0;
    while (key_held && t < 60) begin
      step(1);
      t++;
    end
    check({tag, " held_cleared"}, key_held, 1'b0);
    check({tag, " pulse_count"}, nvalid - base, 1);
  endtask

  initial begin
    int base;
    int vbase;
    int t;
    logic [3:0] seen;

    press = 16'h0;
    rst_n = 1'b0;
    step(3);
    check("rst row_n", row_n, 4'b1110);
    check("rst key_code", key_code, 4'h0);
    check("rst key_valid", key_valid, 1'b0);
    check("rst key_held", key_held, 1'b0);
    check("rst key_value", key_value, 32'h0);
    check("rst value_valid", value_valid, 1'b0);

    // Idle rotation: first dwell starts on the first edge after release.
    rst_n = 1'b1;
    step(1);  check("rot e1", row_n, 4'b1110);
    step(2);  check("rot e3", row_n, 4'b1110);
    step(1);  check("rot e4", row_n, 4'b1101);
    step(4);  check("rot e8", row_n, 4'b1011);
    step(4);  check("rot e12", row_n, 4'b0111);
    step(4);  check("rot e16", row_n, 4'b1110);
    step(40); check("idle no pulse", nvalid, 0);

    // Long hold of key 6, then timed release.
    base = nvalid;
    press[1*4+2] = 1'b1;
    step(100);
    check("k6 pulses", nvalid - base, 1);
    check("k6 code", last_code, 4'h6);
    check("k6 held", key_held, 1'b1);
    check("k6 row held", row_n, 4'b1101);
    press[1*4+2] = 1'b0;
    step(17); check("k6 held before release done", key_held, 1'b1);
    step(1);  check("k6 held after release done", key_held, 1'b0);
    check("k6 next row", row_n, 4'b1011);
    check("k6 single pulse", nvalid - base, 1);

    // Bouncing key 1.
    base = nvalid;
    for (int i = 0; i < 3; i++) begin
      press[0] = 1'b1; step(5);
      press[0] = 1'b0; step(5);
    end
    check("bounce no pulse", nvalid - base, 0);
    press[0] = 1'b1;
    step(17); check("bounce early", nvalid - base, 0);
    step(60);
    check("bounce pulse", nvalid - base, 1);
    check("bounce code", last_code, 4'h1);
    press[0] = 1'b0;
    t = 0;
    while (key_held && t < 60) begin step(1); t++; end
    check("bounce release", key_held, 1'b0);

    // Ghost: two columns on row 2.
    base = nvalid;
    press[2*4+0] = 1'b1;
    press[2*4+1] = 1'b1;
    seen = 4'h0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      seen = seen | ~row_n;
    end
    check("ghost no pulse", nvalid - base, 0);
    check("ghost rows scanned", seen, 4'hF);
    check("ghost not held", key_held, 1'b0);
    press[2*4+0] = 1'b0;
    press[2*4+1] = 1'b0;
    step(10);

    // Reset in the middle of DEBOUNCE.
    rst_n = 1'b0;
    press[0] = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(12);
    check("deb row frozen", row_n, 4'b1110);
    base = nvalid;
    rst_n = 1'b0;
    #1;
    check("midrst row_n", row_n, 4'b1110);
    check("midrst key_code", key_code, 4'h0);
    check("midrst key_valid", key_valid, 1'b0);
    check("midrst key_held", key_held, 1'b0);
    check("midrst key_value", key_value, 32'h0);
    check("midrst value_valid", value_valid, 1'b0);
    press[0] = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(40);
    check("midrst no pulse", nvalid - base, 0);

    // Accumulator entry.
    vbase = nvv;
`ifdef KEYPAD_ACCUM_EN
    hit(0, 0, "acc 1");
    hit(0, 1, "acc 2");
    hit(0, 2, "acc 3");
    check("acc value 123", key_value, 32'h00000123);
    check("acc no commit yet", nvv - vbase, 0);
    hit(3, 2, "acc F");
    check("acc F code", last_code, 4'hF);
    check("acc value kept", key_value, 32'h00000123);
    check("acc commit once", nvv - vbase, 1);
    hit(3, 0, "acc E");
    check("acc E code", last_code, 4'hE);
    check("acc cleared", key_value, 32'h0);
`else
    hit(3, 2, "key F");
    check("key F code", last_code, 4'hF);
    hit(3, 0, "key E");
    check("key E code", last_code, 4'hE);
    check("no accum value", key_value, 32'h0);
    check("no accum commit", nvv - vbase, 0);
`endif
    hit(3, 3, "key D");
    check("key D code", last_code, 4'hD);
    hit(3, 1, "key 0");
    check("key 0 code", last_code, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
